max_scheduler: RTL and testbench
================================

# max_scheduler

Round-robin scheduler that shares one max-finder pipeline (the Q-value max reduction over ACTIONS channels) between several requesters, such as agent lanes or next-state lookups. It accepts per-requester Q-vectors, issues at most one vector per cycle into the pipeline, and tags each issue with its requester ID. When the pipeline returns a maximum, the block routes it back to the owning requester. In-flight tracking is a fixed-latency tag shift register aligned to the pipeline depth; a sticky error flags any tag/result misalignment.

## Interface
- DATA_WIDTH, 32, width of one Q-value
- ACTIONS, 4, Q-values per vector (pipeline channel count, power of 2)
- REQUESTERS, 4, number of requesters (2..16)
- MAX_LATENCY, 2, cycles from o_max_valid high to matching i_max_valid high (≥1)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  REQUESTERS  level request, held until o_grant
- i_data  in  DATA_WIDTH*ACTIONS*REQUESTERS  requester r vector at slice r; must be stable while i_req[r]=1
- i_hold  in  1  1 = issue nothing new; in-flight ops still complete
- o_grant  out  REQUESTERS  one-hot, 1-cycle pulse: request accepted
- o_busy  out  REQUESTERS  requester has an op in flight
- o_max_data  out  DATA_WIDTH*ACTIONS  vector to the pipeline
- o_max_valid  out  1  vector valid to the pipeline
- i_max_data  in  DATA_WIDTH  pipeline result; only sampled when i_max_valid=1
- i_max_valid  in  1  pipeline result valid
- o_data  out  DATA_WIDTH  returned maximum, held until next return
- o_done  out  REQUESTERS  one-hot, 1-cycle pulse: o_data belongs to this requester
- o_idle  out  1  no op in flight and no grant this cycle
- o_err  out  1  sticky misalignment flag

## Operation
- Eligibility: elig = i_req & ~o_busy. Both terms are registered, so a requester whose busy clears at edge t is eligible at edge t+1.
- Arbitration: if i_hold=0 and elig≠0, select the first set bit of elig at or after pointer ptr, wrapping modulo REQUESTERS. At the edge, set ptr to winner+1 (wrap to 0). With no winner, ptr holds.
- Issue, registered at the winning edge:
  - o_grant[w]=1
  - o_max_valid=1
  - o_max_data = slice w
  - busy[w]=1
  - push {1, w} into the tag shift register (depth MAX_LATENCY)
- With no issue: o_grant=0, o_max_valid=0, o_max_data holds its previous value, and push {0, x}.
- Return, evaluated on the tag-register tail:
  - Tail valid and i_max_valid=1: o_data=i_max_data, o_done[tag]=1, busy[tag]=0.
  - Tail valid and i_max_valid=0: busy[tag]=0, no done, o_err=1.
  - Tail invalid and i_max_valid=1: result dropped, o_err=1.
- Same-requester issue and return at one edge cannot occur, because busy blocks reissue.
- Different-requester issue and return at the same edge: both take effect.
- i_hold never flushes in-flight ops. o_idle = no valid tag entry and o_max_valid=0.
- o_err is cleared only by rst.

## Timing
- Reset (async, immediate) sets:
  - o_grant=0, o_busy=0, o_max_valid=0, o_max_data=0
  - o_data=0, o_done=0, o_err=0, o_idle=1
  - ptr=0, all tag entries invalid
- Request to grant: i_req sampled at edge t gives o_grant and o_max_valid high during cycle t+1.
- Issue to done: o_done is high MAX_LATENCY+1 cycles after o_max_valid first goes high. That is the pipeline latency plus one return register.
- Throughput: one issue per cycle across requesters. Per requester, the issue-to-issue interval is at least MAX_LATENCY+3 cycles.
- rst asserted mid-operation discards all in-flight tags. Pipeline results arriving after rst is released set o_err, because their tags are invalid.

## Test plan
- Single request: REQUESTERS=4, MAX_LATENCY=2, r1 requests vector {5,9,3,7}.
  - Required: o_grant=0010 at t+1; o_done=0010 at t+4 with o_data=9; o_busy[1] high t+1..t+4.
- Fairness: all four requesters hold i_req continuously.
  - Required: grants are 0001,0010,0100,1000 on consecutive cycles, then r0 is regranted once its busy clears; no requester is starved.
- Hold: assert i_hold for 5 cycles with 2 ops in flight.
  - Required: no new o_grant; both o_done pulses still arrive; o_idle=1 afterwards; ptr is unchanged.
- Misalignment:
  - Inject i_max_valid with no tag: o_err=1 and stays set.
  - Separately, suppress i_max_valid for an issued op: busy clears, no o_done, o_err=1.
- Simultaneous issue and return: r2's result returns on the same edge r3 is granted.
  - Required: o_done=0100 and o_grant=1000 in the same cycle; correct o_data.
- Reset mid-operation: assert rst with 3 ops in flight.
  - Required: all outputs are at reset values immediately; after release, late pipeline returns produce o_err=1 and no o_done.

Source files
------------

// File: rtl/max_scheduler_if.sv
// Bundle of requester, pipeline and status signals around the shared max-finder scheduler.
// The master side drives requests and pipeline results; the scheduler is the slave.
interface max_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ACTIONS    = 4,
    parameter int REQUESTERS = 4
);
    logic [REQUESTERS-1:0]                       i_req;
    logic [DATA_WIDTH*ACTIONS*REQUESTERS-1:0]    i_data;
    logic                                        i_hold;
    logic [REQUESTERS-1:0]                       o_grant;
    logic [REQUESTERS-1:0]                       o_busy;
    logic [DATA_WIDTH*ACTIONS-1:0]               o_max_data;
    logic                                        o_max_valid;
    logic [DATA_WIDTH-1:0]                       i_max_data;
    logic                                        i_max_valid;
    logic [DATA_WIDTH-1:0]                       o_data;
    logic [REQUESTERS-1:0]                       o_done;
    logic                                        o_idle;
    logic                                        o_err;

    modport master (
        output i_req, i_data, i_hold, i_max_data, i_max_valid,
        input  o_grant, o_busy, o_max_data, o_max_valid, o_data, o_done, o_idle, o_err
    );

    modport slave (
        input  i_req, i_data, i_hold, i_max_data, i_max_valid,
        output o_grant, o_busy, o_max_data, o_max_valid, o_data, o_done, o_idle, o_err
    );
endinterface

// File: rtl/max_scheduler.sv
// Round-robin scheduler sharing one max-finder pipeline between REQUESTERS lanes.
// Issue tags ride a fixed-latency pipe; results are routed back by the tag at its tail.
module max_scheduler #(
    parameter int DATA_WIDTH  = 32,
    parameter int ACTIONS     = 4,
    parameter int REQUESTERS  = 4,
    parameter int MAX_LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    max_scheduler_if.slave bus
);
    localparam int VW  = DATA_WIDTH * ACTIONS;
    localparam int IDW = $clog2(REQUESTERS);

    logic [IDW-1:0]                   ptr;
    logic [IDW-1:0]                   win;
    logic                             win_vld;
    logic                             issue;
    logic [REQUESTERS-1:0]            elig;
    logic [REQUESTERS-1:0]            busy;
    logic [REQUESTERS-1:0]            clr_q;
    logic [REQUESTERS-1:0]            grant_q;
    logic [REQUESTERS-1:0]            done_q;
    logic [VW-1:0]                    sel_vec;
    logic [VW-1:0]                    max_data_q;
    logic [DATA_WIDTH-1:0]            data_q;
    logic                             err_q;
    // Stage 0 is the issue register itself (o_max_valid); stage MAX_LATENCY lines up with i_max_valid.
    logic [MAX_LATENCY:0]             vld_pipe;
    logic [MAX_LATENCY:0][IDW-1:0]    tag_pipe;

    function automatic logic [REQUESTERS-1:0] oh(input logic [IDW-1:0] id);
        return {{(REQUESTERS-1){1'b0}}, 1'b1} << id;
    endfunction

    assign elig = bus.i_req & ~busy;

    always_comb begin : arb
        int j;
        j       = 0;
        win     = '0;
        win_vld = 1'b0;
        // Walk downward so the smallest offset from ptr is the final assignment.
        for (int i = REQUESTERS - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= REQUESTERS) j = j - REQUESTERS;
            if (elig[j]) begin
                win     = IDW'(j);
                win_vld = 1'b1;
            end
        end
    end

    assign issue   = win_vld & ~bus.i_hold;
    assign sel_vec = bus.i_data[int'(win)*VW +: VW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            grant_q    <= '0;
            busy       <= '0;
            clr_q      <= '0;
            done_q     <= '0;
            max_data_q <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            vld_pipe   <= '0;
            tag_pipe   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[MAX_LATENCY-1:0], issue};
            tag_pipe <= {tag_pipe[MAX_LATENCY-1:0], win};
            grant_q  <= issue ? oh(win) : '0;
            busy     <= (busy & ~clr_q) | (issue ? oh(win) : '0);
            if (issue) begin
                ptr        <= (win == IDW'(REQUESTERS - 1)) ? '0 : win + 1'b1;
                max_data_q <= sel_vec;
            end
            done_q <= '0;
            clr_q  <= '0;
            // Busy drops one cycle after the return so the done pulse overlaps busy.
            if (vld_pipe[MAX_LATENCY]) begin
                clr_q <= oh(tag_pipe[MAX_LATENCY]);
                if (bus.i_max_valid) begin
                    done_q <= oh(tag_pipe[MAX_LATENCY]);
                    data_q <= bus.i_max_data;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (bus.i_max_valid) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.o_grant     = grant_q;
    assign bus.o_busy      = busy;
    assign bus.o_max_data  = max_data_q;
    assign bus.o_max_valid = vld_pipe[0];
    assign bus.o_data      = data_q;
    assign bus.o_done      = done_q;
    assign bus.o_err       = err_q;
    assign bus.o_idle      = ~|vld_pipe;
endmodule

// File: tb/tb_max_scheduler.sv
// Directed bench for max_scheduler with a behavioural two-stage max-finder pipeline.
module tb_max_scheduler;
    localparam int L = 2;

    logic clk, rst;
    int   checks = 0;
    int   passed = 0;
    logic inject = 1'b0;
    logic kill   = 1'b0;
    logic [L-1:0]       pv = '0;
    logic [L-1:0][31:0] pd = '0;

    max_scheduler_if #(.DATA_WIDTH(32), .ACTIONS(4), .REQUESTERS(4)) bif ();

    max_scheduler #(.DATA_WIDTH(32), .ACTIONS(4), .REQUESTERS(4), .MAX_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] max4(input logic [127:0] v);
        logic [31:0] m;
        m = v[31:0];
        for (int k = 1; k < 4; k++) if (v[k*32 +: 32] > m) m = v[k*32 +: 32];
        return m;
    endfunction

    // Pipeline is not reset, so results in flight across rst still emerge.
    always @(posedge clk) begin
        pv <= {pv[0], bif.o_max_valid};
        pd <= {pd[0], max4(bif.o_max_data)};
    end
    assign bif.i_max_valid = (pv[L-1] & ~kill) | inject;
    assign bif.i_max_data  = pd[L-1];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int r, input logic [31:0] a0, a1, a2, a3);
        bif.i_data[r*128 +: 128] = {a3, a2, a1, a0};
    endtask

    task automatic do_reset;
        rst = 1'b1; bif.i_req = '0; bif.i_hold = 1'b0; inject = 1'b0; kill = 1'b0;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            tick;
            if (bif.o_busy == 4'b0 && bif.o_idle) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; bif.i_req = '0; bif.i_hold = 1'b0; bif.i_data = '0;
        tick; tick;
        checks++; if (bif.o_grant !== 4'b0) $display("FAIL rst_grant got %b want 0000", bif.o_grant); else passed++;
        checks++; if (bif.o_busy !== 4'b0) $display("FAIL rst_busy got %b want 0000", bif.o_busy); else passed++;
        checks++; if (bif.o_max_valid !== 1'b0 || bif.o_max_data !== '0) $display("FAIL rst_maxout got %b/%h want 0/0", bif.o_max_valid, bif.o_max_data); else passed++;
        checks++; if (bif.o_data !== 32'd0 || bif.o_done !== 4'b0) $display("FAIL rst_done got %h/%b want 0/0000", bif.o_data, bif.o_done); else passed++;
        checks++; if (bif.o_err !== 1'b0 || bif.o_idle !== 1'b1) $display("FAIL rst_flags got err=%b idle=%b want 0/1", bif.o_err, bif.o_idle); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_single;
        logic [127:0] ev;
        bit ok;
        do_reset;
        set_vec(1, 5, 9, 3, 7);
        ev = {32'd7, 32'd3, 32'd9, 32'd5};
        bif.i_req = 4'b0010;
        tick;
        checks++; if (bif.o_grant !== 4'b0010 || bif.o_max_valid !== 1'b1) $display("FAIL single_grant got %b/%b want 0010/1", bif.o_grant, bif.o_max_valid); else passed++;
        checks++; if (bif.o_max_data !== ev) $display("FAIL single_vec got %h want %h", bif.o_max_data, ev); else passed++;
        checks++; if (bif.o_busy !== 4'b0010 || bif.o_idle !== 1'b0) $display("FAIL single_busy1 got %b/%b want 0010/0", bif.o_busy, bif.o_idle); else passed++;
        bif.i_req = '0;
        tick;
        checks++; if (bif.o_grant !== 4'b0 || bif.o_max_valid !== 1'b0 || bif.o_max_data !== ev) $display("FAIL single_pulse got %b/%b/%h want 0000/0/%h", bif.o_grant, bif.o_max_valid, bif.o_max_data, ev); else passed++;
        tick;
        checks++; if (bif.o_busy !== 4'b0010 || bif.o_done !== 4'b0) $display("FAIL single_t3 got busy=%b done=%b want 0010/0000", bif.o_busy, bif.o_done); else passed++;
        tick;
        checks++; if (bif.o_done !== 4'b0010 || bif.o_data !== 32'd9 || bif.o_busy !== 4'b0010) $display("FAIL single_done got %b/%0d/%b want 0010/9/0010", bif.o_done, bif.o_data, bif.o_busy); else passed++;
        tick;
        checks++; if (bif.o_done !== 4'b0 || bif.o_busy !== 4'b0 || bif.o_idle !== 1'b1) $display("FAIL single_end got %b/%b/%b want 0000/0000/1", bif.o_done, bif.o_busy, bif.o_idle); else passed++;
        drain(ok);
    endtask

    task automatic test_fairness;
        logic [3:0] eg [7];
        logic [3:0] ed [7];
        logic [31:0] edat [7];
        bit ok;
        eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001, 4'b0010};
        ed = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        edat = '{0, 0, 0, 100, 101, 102, 103};
        do_reset;
        for (int k = 0; k < 4; k++) set_vec(k, k + 1, 100 + k, k + 2, k + 3);
        bif.i_req = 4'b1111;
        for (int c = 0; c < 7; c++) begin
            tick;
            checks++; if (bif.o_grant !== eg[c]) $display("FAIL fair_grant[%0d] got %b want %b", c, bif.o_grant, eg[c]); else passed++;
            checks++; if (bif.o_done !== ed[c]) $display("FAIL fair_done[%0d] got %b want %b", c, bif.o_done, ed[c]); else passed++;
            if (ed[c] != 4'b0) begin
                checks++; if (bif.o_data !== edat[c]) $display("FAIL fair_data[%0d] got %0d want %0d", c, bif.o_data, edat[c]); else passed++;
            end
        end
        bif.i_req = '0;
        drain(ok);
        checks++; if (!ok) $display("FAIL fair_drain got busy=%b idle=%b want 0000/1", bif.o_busy, bif.o_idle); else passed++;
    endtask

    task automatic test_hold;
        logic [3:0] hd [5];
        logic [31:0] hdat [5];
        bit ok;
        hd = '{4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0000};
        hdat = '{0, 100, 101, 0, 0};
        do_reset;
        bif.i_req = 4'b0011;
        tick;
        checks++; if (bif.o_grant !== 4'b0001) $display("FAIL hold_g0 got %b want 0001", bif.o_grant); else passed++;
        bif.i_req = 4'b0010;
        tick;
        checks++; if (bif.o_grant !== 4'b0010) $display("FAIL hold_g1 got %b want 0010", bif.o_grant); else passed++;
        bif.i_req = 4'b1100; bif.i_hold = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick;
            checks++; if (bif.o_grant !== 4'b0) $display("FAIL hold_nogrant[%0d] got %b want 0000", c, bif.o_grant); else passed++;
            checks++; if (bif.o_done !== hd[c]) $display("FAIL hold_done[%0d] got %b want %b", c, bif.o_done, hd[c]); else passed++;
            if (hd[c] != 4'b0) begin
                checks++; if (bif.o_data !== hdat[c]) $display("FAIL hold_data[%0d] got %0d want %0d", c, bif.o_data, hdat[c]); else passed++;
            end
        end
        checks++; if (bif.o_idle !== 1'b1 || bif.o_busy !== 4'b0) $display("FAIL hold_idle got %b/%b want 1/0000", bif.o_idle, bif.o_busy); else passed++;
        bif.i_hold = 1'b0;
        tick;
        checks++; if (bif.o_grant !== 4'b0100) $display("FAIL hold_ptr got %b want 0100", bif.o_grant); else passed++;
        bif.i_req = 4'b1000;
        tick;
        checks++; if (bif.o_grant !== 4'b1000) $display("FAIL hold_next got %b want 1000", bif.o_grant); else passed++;
        bif.i_req = '0;
        drain(ok);
    endtask

    task automatic test_simul;
        bit ok;
        do_reset;
        bif.i_req = 4'b0100;
        tick;
        checks++; if (bif.o_grant !== 4'b0100) $display("FAIL simul_g2 got %b want 0100", bif.o_grant); else passed++;
        bif.i_req = '0;
        tick; tick;
        bif.i_req = 4'b1000;
        tick;
        checks++; if (bif.o_done !== 4'b0100 || bif.o_grant !== 4'b1000) $display("FAIL simul_both got done=%b grant=%b want 0100/1000", bif.o_done, bif.o_grant); else passed++;
        checks++; if (bif.o_data !== 32'd102) $display("FAIL simul_data got %0d want 102", bif.o_data); else passed++;
        bif.i_req = '0;
        drain(ok);
        checks++; if (!ok) $display("FAIL simul_drain got busy=%b idle=%b want 0000/1", bif.o_busy, bif.o_idle); else passed++;
    endtask

    task automatic test_reset_mid;
        bit ok;
        bif.i_req = 4'b0111;
        tick;
        checks++; if (bif.o_grant !== 4'b0001) $display("FAIL rmid_g0 got %b want 0001", bif.o_grant); else passed++;
        bif.i_req = 4'b0110;
        tick;
        checks++; if (bif.o_grant !== 4'b0010) $display("FAIL rmid_g1 got %b want 0010", bif.o_grant); else passed++;
        bif.i_req = 4'b0100;
        tick;
        checks++; if (bif.o_grant !== 4'b0100) $display("FAIL rmid_g2 got %b want 0100", bif.o_grant); else passed++;
        bif.i_req = '0;
        #2 rst = 1'b1;
        #1;
        checks++; if (bif.o_grant !== 4'b0 || bif.o_busy !== 4'b0 || bif.o_max_valid !== 1'b0) $display("FAIL rmid_async got %b/%b/%b want 0000/0000/0", bif.o_grant, bif.o_busy, bif.o_max_valid); else passed++;
        checks++; if (bif.o_data !== 32'd0 || bif.o_max_data !== '0 || bif.o_idle !== 1'b1 || bif.o_err !== 1'b0) $display("FAIL rmid_vals got %h/%h/%b/%b want 0/0/1/0", bif.o_data, bif.o_max_data, bif.o_idle, bif.o_err); else passed++;
        tick;
        rst = 1'b0;
        tick;
        checks++; if (bif.o_err !== 1'b1 || bif.o_done !== 4'b0) $display("FAIL rmid_late1 got err=%b done=%b want 1/0000", bif.o_err, bif.o_done); else passed++;
        tick;
        checks++; if (bif.o_err !== 1'b1 || bif.o_done !== 4'b0) $display("FAIL rmid_late2 got err=%b done=%b want 1/0000", bif.o_err, bif.o_done); else passed++;
        drain(ok);
    endtask

    task automatic test_err_inject;
        do_reset;
        tick;
        checks++; if (bif.o_err !== 1'b0) $display("FAIL inj_pre got %b want 0", bif.o_err); else passed++;
        inject = 1'b1;
        tick;
        inject = 1'b0;
        checks++; if (bif.o_err !== 1'b1 || bif.o_done !== 4'b0) $display("FAIL inj_err got err=%b done=%b want 1/0000", bif.o_err, bif.o_done); else passed++;
        tick; tick;
        checks++; if (bif.o_err !== 1'b1) $display("FAIL inj_sticky got %b want 1", bif.o_err); else passed++;
    endtask

    task automatic test_err_suppress;
        bit ok;
        do_reset;
        bif.i_req = 4'b0001;
        tick;
        checks++; if (bif.o_grant !== 4'b0001) $display("FAIL sup_grant got %b want 0001", bif.o_grant); else passed++;
        bif.i_req = '0; kill = 1'b1;
        tick; tick;
        checks++; if (bif.o_err !== 1'b0) $display("FAIL sup_pre got %b want 0", bif.o_err); else passed++;
        tick;
        checks++; if (bif.o_err !== 1'b1 || bif.o_done !== 4'b0 || bif.o_busy !== 4'b0001) $display("FAIL sup_ret got err=%b done=%b busy=%b want 1/0000/0001", bif.o_err, bif.o_done, bif.o_busy); else passed++;
        tick;
        checks++; if (bif.o_busy !== 4'b0 || bif.o_done !== 4'b0) $display("FAIL sup_clr got busy=%b done=%b want 0000/0000", bif.o_busy, bif.o_done); else passed++;
        kill = 1'b0;
        drain(ok);
    endtask

    initial begin
        test_reset;
        test_single;
        test_fairness;
        test_hold;
        test_simul;
        test_reset_mid;
        test_err_inject;
        test_err_suppress;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
